fractal_sync_node_2x1: RTL and testbench

Binary synchronization-tree node that merges barrier requests from two child ports into one parent port. Requests whose level targets this node are resolved locally. Requests with a higher level are forwarded upward with the level decremented by one. The parent's wake/error response is relayed back to both children. The topmost instance's parent port is normally driven by the tree monitor, which answers a sync with held wake/error until it sees ack.

---
 rtl/fractal_sync_node_2x1.sv | 134 +++++++++++++
 tb/tb_fractal_sync_node_2x1.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_node_2x1.sv
// Binary sync-tree node: merges barrier requests from two children, resolves
// them locally or forwards them to the parent, and relays the parent's answer.
module fractal_sync_node_2x1 #(
    parameter int LVL_WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               c_sync_i,
    input  logic [2*LVL_WIDTH-1:0]   c_lvl_i,
    input  logic [1:0]               c_ack_i,
    output logic [1:0]               c_wake_o,
    output logic [1:0]               c_error_o,
    output logic                     p_sync_o,
    output logic [LVL_WIDTH-1:0]     p_lvl_o,
    output logic                     p_ack_o,
    input  logic                     p_wake_i,
    input  logic                     p_error_i,
    output logic                     viol_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [LVL_WIDTH-1:0] LVL_ZERO = '0;
    localparam logic [LVL_WIDTH-1:0] LVL_ONE  = LVL_WIDTH'(1);

    logic [1:0]                  state_q, state_d;
    logic [1:0]                  pend_q, pend_d;
    logic [1:0][LVL_WIDTH-1:0]   lvl_q, lvl_d;
    logic [1:0]                  tgt_q, tgt_d;
    logic                        err_q, err_d;
    logic                        viol_q, viol_d;
    logic                        parent_resp;
    logic [1:0]                  ack_hit;

    assign parent_resp = p_wake_i | p_error_i;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        lvl_d   = lvl_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        viol_d  = viol_q;
        ack_hit = tgt_q & c_ack_i;

        case (state_q)
            ST_IDLE: begin
                if (pend_q == 2'b11) begin
                    // Mismatched or zero levels cannot form a valid barrier.
                    if ((lvl_q[0] != lvl_q[1]) || (lvl_q[0] == LVL_ZERO)) begin
                        tgt_d   = 2'b11;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (lvl_q[0] == LVL_ONE) begin
                        tgt_d   = 2'b11;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_FWD;
                    end
                end else if (pend_q[0] && (lvl_q[0] == LVL_ZERO)) begin
                    tgt_d   = 2'b01;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (pend_q[1] && (lvl_q[1] == LVL_ZERO)) begin
                    tgt_d   = 2'b10;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_FWD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (parent_resp) begin
                    err_d   = p_error_i;
                    tgt_d   = 2'b11;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                tgt_d  = tgt_q & ~c_ack_i;
                pend_d = pend_q & ~ack_hit;
                if (tgt_d == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New requests are only accepted in IDLE; anything else is a violation.
        for (int i = 0; i < 2; i++) begin
            if (c_sync_i[i]) begin
                if ((state_q == ST_IDLE) && !pend_q[i]) begin
                    pend_d[i] = 1'b1;
                    lvl_d[i]  = c_lvl_i[i*LVL_WIDTH +: LVL_WIDTH];
                end else begin
                    viol_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            lvl_q   <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            lvl_q   <= lvl_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            viol_q  <= viol_d;
        end
    end

    assign c_wake_o  = (state_q == ST_RESP) ? tgt_q : 2'b00;
    assign c_error_o = c_wake_o & {2{err_q}};
    assign p_sync_o  = (state_q == ST_FWD);
    assign p_lvl_o   = p_sync_o ? (lvl_q[0] - LVL_ONE) : LVL_ZERO;
    assign p_ack_o   = (state_q == ST_WAIT) && parent_resp;
    assign viol_o    = viol_q;

endmodule

// File: tb/tb_fractal_sync_node_2x1.sv
// Directed bench for fractal_sync_node_2x1: expected child responses and parent
// forwards are queued when stimulus is driven and checked when the DUT answers.
module tb_fractal_sync_node_2x1;

    localparam int LW = 2;

    logic            clk;
    logic            rst_i;
    logic [1:0]      c_sync_i;
    logic [2*LW-1:0] c_lvl_i;
    logic [1:0]      c_ack_i;
    logic [1:0]      c_wake_o;
    logic [1:0]      c_error_o;
    logic            p_sync_o;
    logic [LW-1:0]   p_lvl_o;
    logic            p_ack_o;
    logic            p_wake_i;
    logic            p_error_i;
    logic            viol_o;

    typedef struct {
        logic [1:0] wake;
        logic [1:0] err;
        int         lat;
    } resp_t;

    typedef struct {
        logic [LW-1:0] lvl;
        int            lat;
    } fwd_t;

    resp_t resp_q[$];
    fwd_t  fwd_q[$];
    int    checks = 0;
    int    errors = 0;

    fractal_sync_node_2x1 #(.LVL_WIDTH(LW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .c_sync_i  (c_sync_i),
        .c_lvl_i   (c_lvl_i),
        .c_ack_i   (c_ack_i),
        .c_wake_o  (c_wake_o),
        .c_error_o (c_error_o),
        .p_sync_o  (p_sync_o),
        .p_lvl_o   (p_lvl_o),
        .p_ack_o   (p_ack_o),
        .p_wake_i  (p_wake_i),
        .p_error_i (p_error_i),
        .viol_o    (viol_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one sync pulse at the current negedge and returns at the next one.
    task automatic applyStimulus(input logic [1:0] sync, input logic [LW-1:0] l0, input logic [LW-1:0] l1);
        c_sync_i = sync;
        c_lvl_i  = {l1, l0};
        @(negedge clk);
        c_sync_i = 2'b00;
        c_lvl_i  = '0;
    endtask

    task automatic expectResp(input logic [1:0] w, input logic [1:0] e, input int lat);
        resp_t r;
        r.wake = w;
        r.err  = e;
        r.lat  = lat;
        resp_q.push_back(r);
    endtask

    task automatic expectFwd(input logic [LW-1:0] l, input int lat);
        fwd_t f;
        f.lvl = l;
        f.lat = lat;
        fwd_q.push_back(f);
    endtask

    task automatic waitResp(input string tag);
        resp_t r;
        int n;
        n = 0;
        r = resp_q.pop_front();
        do begin
            @(negedge clk);
            n++;
        end while ((c_wake_o == 2'b00) && (n < 20));
        checkOutput({tag, "_lat"}, 8'(n), 8'(r.lat));
        checkOutput({tag, "_wake"}, {6'd0, c_wake_o}, {6'd0, r.wake});
        checkOutput({tag, "_err"}, {6'd0, c_error_o}, {6'd0, r.err});
    endtask

    task automatic waitFwd(input string tag);
        fwd_t f;
        int n;
        n = 0;
        f = fwd_q.pop_front();
        do begin
            @(negedge clk);
            n++;
        end while (!p_sync_o && (n < 20));
        checkOutput({tag, "_lat"}, 8'(n), 8'(f.lat));
        checkOutput({tag, "_plvl"}, {6'd0, p_lvl_o}, {6'd0, f.lvl});
        checkOutput({tag, "_nowake"}, {6'd0, c_wake_o}, 8'd0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {7'd0, p_sync_o}, 8'd0);
    endtask

    task automatic ackChildren(input logic [1:0] mask);
        c_ack_i = mask;
        @(negedge clk);
        c_ack_i = 2'b00;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wake"}, {6'd0, c_wake_o}, 8'd0);
        checkOutput({tag, "_err"}, {6'd0, c_error_o}, 8'd0);
        checkOutput({tag, "_psync"}, {7'd0, p_sync_o}, 8'd0);
        checkOutput({tag, "_plvl"}, {6'd0, p_lvl_o}, 8'd0);
        checkOutput({tag, "_pack"}, {7'd0, p_ack_o}, 8'd0);
        checkOutput({tag, "_viol"}, {7'd0, viol_o}, 8'd0);
    endtask

    initial begin
        rst_i     = 1'b1;
        c_sync_i  = 2'b00;
        c_lvl_i   = '0;
        c_ack_i   = 2'b00;
        p_wake_i  = 1'b0;
        p_error_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        checkAllZero("reset");

        $display("[TB] local barrier");
        applyStimulus(2'b01, 2'd1, 2'd0);
        @(negedge clk);
        checkOutput("local_early", {6'd0, c_wake_o}, 8'd0);
        @(negedge clk);
        expectResp(2'b11, 2'b00, 1);
        applyStimulus(2'b10, 2'd0, 2'd1);
        waitResp("local");
        ackChildren(2'b01);
        checkOutput("local_ack0_wake", {6'd0, c_wake_o}, 8'd2);
        ackChildren(2'b10);
        checkOutput("local_ack1_wake", {6'd0, c_wake_o}, 8'd0);
        checkOutput("local_viol", {7'd0, viol_o}, 8'd0);

        $display("[TB] forward");
        expectFwd(2'd2, 1);
        applyStimulus(2'b11, 2'd3, 2'd3);
        waitFwd("fwd3");
        repeat (2) @(negedge clk);
        checkOutput("fwd3_idlewake", {6'd0, c_wake_o}, 8'd0);
        p_wake_i = 1'b1;
        #1;
        checkOutput("fwd3_ack_first", {7'd0, p_ack_o}, 8'd1);
        expectResp(2'b11, 2'b00, 1);
        waitResp("fwd3_resp");
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("fwd3_ack_single", {7'd0, p_ack_o}, 8'd0);
            @(negedge clk);
        end
        p_wake_i = 1'b0;
        checkOutput("fwd3_held", {6'd0, c_wake_o}, 8'd3);
        ackChildren(2'b11);
        checkOutput("fwd3_done", {6'd0, c_wake_o}, 8'd0);

        $display("[TB] level mismatch");
        expectResp(2'b11, 2'b11, 1);
        applyStimulus(2'b11, 2'd1, 2'd2);
        waitResp("mismatch");
        checkOutput("mismatch_psync", {7'd0, p_sync_o}, 8'd0);
        ackChildren(2'b11);

        $display("[TB] illegal level");
        expectResp(2'b01, 2'b01, 1);
        applyStimulus(2'b01, 2'd0, 2'd0);
        waitResp("illegal");
        ackChildren(2'b01);
        checkOutput("illegal_done", {6'd0, c_wake_o}, 8'd0);
        expectResp(2'b11, 2'b00, 1);
        applyStimulus(2'b11, 2'd1, 2'd1);
        waitResp("illegal_retry");
        ackChildren(2'b11);
        checkOutput("illegal_viol", {7'd0, viol_o}, 8'd0);

        $display("[TB] parent error");
        expectFwd(2'd1, 1);
        applyStimulus(2'b11, 2'd2, 2'd2);
        waitFwd("perr");
        p_wake_i  = 1'b1;
        p_error_i = 1'b1;
        #1;
        checkOutput("perr_ack", {7'd0, p_ack_o}, 8'd1);
        expectResp(2'b11, 2'b11, 1);
        waitResp("perr_resp");
        p_wake_i  = 1'b0;
        p_error_i = 1'b0;
        checkOutput("perr_viol", {7'd0, viol_o}, 8'd0);
        ackChildren(2'b11);

        $display("[TB] violation and reset");
        applyStimulus(2'b01, 2'd2, 2'd0);
        checkOutput("viol_first", {7'd0, viol_o}, 8'd0);
        applyStimulus(2'b01, 2'd2, 2'd0);
        checkOutput("viol_set", {7'd0, viol_o}, 8'd1);
        repeat (3) @(negedge clk);
        checkOutput("viol_sticky", {7'd0, viol_o}, 8'd1);
        expectFwd(2'd1, 1);
        applyStimulus(2'b10, 2'd0, 2'd2);
        waitFwd("viol_fwd");
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checkAllZero("wait_reset");
        expectResp(2'b11, 2'b00, 1);
        applyStimulus(2'b11, 2'd1, 2'd1);
        waitResp("post_reset");
        ackChildren(2'b11);
        checkOutput("post_reset_done", {6'd0, c_wake_o}, 8'd0);
        checkOutput("post_reset_viol", {7'd0, viol_o}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
